// File: rtl/hus_mixer.sv
// HUS stereo mixer: accumulates per-channel products into a frame mix, saturates
// to 16 bits, double-buffers it and shifts it out to a left-justified stereo DAC.
module hus_mixer #(
    parameter int BCLK_DIV = 4,
    parameter int ACC_W    = 28
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               au_stb,
    input  logic               mix_start,
    input  logic               mix_vld,
    input  logic signed [15:0] mix_smp,
    input  logic [5:0]         mix_vol_l,
    input  logic [5:0]         mix_vol_r,
    input  logic               mix_end,
    output logic               dac_bclk,
    output logic               dac_lrck,
    output logic               dac_dat,
    output logic               busy,
    output logic               ovf,
    output logic               urun,
    input  logic               flg_clr
);

    localparam int PH_W = (2 * BCLK_DIV > 2) ? $clog2(2 * BCLK_DIV) : 1;
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(2 * BCLK_DIV - 1);
    localparam logic [PH_W-1:0] PH_RISE = PH_W'(BCLK_DIV - 1);
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(32767);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-32768);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t                    state;
    logic signed [ACC_W-1:0]   acc_l, acc_r;
    logic signed [ACC_W-1:0]   acc_nxt_l, acc_nxt_r;
    logic signed [22:0]        prod_l, prod_r;
    logic signed [ACC_W-1:0]   prod_ext_l, prod_ext_r;
    logic signed [15:0]        pending_l, pending_r;
    logic                      pending_vld;
    logic signed [15:0]        hold_l, hold_r;
    logic [31:0]               load_word;
    logic [31:0]               sreg;
    logic [PH_W-1:0]           phase;
    logic [4:0]                bit_cnt;
    logic [4:0]                bit_nxt;
    logic                      consume;
    logic                      clip_any;

    function automatic logic signed [15:0] sat16(input logic signed [ACC_W-1:0] v);
        logic signed [ACC_W-1:0] s;
        s = v >>> 6;
        if (s > SAT_MAX)
            return 16'sh7FFF;
        else if (s < SAT_MIN)
            return 16'sh8000;
        else
            return s[15:0];
    endfunction

    function automatic logic clips(input logic signed [ACC_W-1:0] v);
        logic signed [ACC_W-1:0] s;
        s = v >>> 6;
        return (s > SAT_MAX) || (s < SAT_MIN);
    endfunction

    // Volume is zero-extended so 63 stays positive in the signed multiply.
    assign prod_l = $signed({{7{mix_smp[15]}}, mix_smp}) * $signed({17'b0, mix_vol_l});
    assign prod_r = $signed({{7{mix_smp[15]}}, mix_smp}) * $signed({17'b0, mix_vol_r});
    assign prod_ext_l = {{(ACC_W-23){prod_l[22]}}, prod_l};
    assign prod_ext_r = {{(ACC_W-23){prod_r[22]}}, prod_r};

    always_comb begin
        acc_nxt_l = mix_start ? '0 : acc_l;
        acc_nxt_r = mix_start ? '0 : acc_r;
        if (mix_vld) begin
            acc_nxt_l = acc_nxt_l + prod_ext_l;
            acc_nxt_r = acc_nxt_r + prod_ext_r;
        end
    end

    assign clip_any  = clips(acc_nxt_l) || clips(acc_nxt_r);
    assign consume   = (state == IDLE) && au_stb && pending_vld;
    assign load_word = pending_vld ? {pending_l, pending_r} : {hold_l, hold_r};
    assign bit_nxt   = bit_cnt + 5'd1;

    // Mix accumulation and pending buffer; a fresh mix_end beats a same-cycle consume.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_l       <= '0;
            acc_r       <= '0;
            pending_l   <= '0;
            pending_r   <= '0;
            pending_vld <= 1'b0;
        end else begin
            acc_l <= acc_nxt_l;
            acc_r <= acc_nxt_r;
            if (mix_end) begin
                pending_l   <= sat16(acc_nxt_l);
                pending_r   <= sat16(acc_nxt_r);
                pending_vld <= 1'b1;
            end else if (consume) begin
                pending_vld <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf  <= 1'b0;
            urun <= 1'b0;
        end else begin
            if (flg_clr)
                ovf <= 1'b0;
            else if (mix_end && clip_any)
                ovf <= 1'b1;
            if (flg_clr)
                urun <= 1'b0;
            else if (au_stb && state == SHIFT)
                urun <= 1'b1;
        end
    end

    // Serialiser: outputs are registered one cycle ahead of the bit they describe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            hold_l   <= '0;
            hold_r   <= '0;
            sreg     <= '0;
            phase    <= '0;
            bit_cnt  <= '0;
            dac_bclk <= 1'b0;
            dac_lrck <= 1'b0;
            dac_dat  <= 1'b0;
            busy     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (au_stb) begin
                        if (pending_vld) begin
                            hold_l <= pending_l;
                            hold_r <= pending_r;
                        end
                        sreg     <= load_word;
                        dac_dat  <= load_word[31];
                        dac_lrck <= 1'b0;
                        dac_bclk <= 1'b0;
                        busy     <= 1'b1;
                        phase    <= '0;
                        bit_cnt  <= '0;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (phase == PH_LAST) begin
                        phase    <= '0;
                        dac_bclk <= 1'b0;
                        if (bit_cnt == 5'd31) begin
                            dac_dat  <= 1'b0;
                            dac_lrck <= 1'b0;
                            busy     <= 1'b0;
                            state    <= IDLE;
                        end else begin
                            bit_cnt  <= bit_nxt;
                            sreg     <= {sreg[30:0], 1'b0};
                            dac_dat  <= sreg[30];
                            dac_lrck <= bit_nxt[4];
                        end
                    end else begin
                        phase <= phase + PH_W'(1);
                        if (phase == PH_RISE)
                            dac_bclk <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
